// File: rtl/mem_pkg.sv
// Shared encodings for the ThinPad memory stage: request codes, FSM state enum and UART addresses.
`default_nettype none

package mem_pkg;

  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;
  localparam logic [1:0] MEM_NONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR1  = 3'd2,
    S_WR2  = 3'd3,
    S_UR   = 3'd4,
    S_UW   = 3'd5,
    S_DONE = 3'd6
  } mem_state_e;

  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory-stage controller: sequences SRAM and UART accesses and stalls the pipeline until done.
`default_nettype none

module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  controlMem,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        mem_stall,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  input  logic [15:0] ram_din,
  output logic        ram_doe,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_RD   = S_RD;
  localparam logic [2:0] ST_WR1  = S_WR1;
  localparam logic [2:0] ST_WR2  = S_WR2;
  localparam logic [2:0] ST_UR   = S_UR;
  localparam logic [2:0] ST_UW   = S_UW;
  localparam logic [2:0] ST_DONE = S_DONE;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_rdata;
  logic        r_hold;
  logic        w_is_rd;
  logic        w_is_wr;
  logic        w_is_udata;
  logic        w_is_ustat;
  logic        w_drive;

  assign w_is_rd    = (controlMem == MEM_RD);
  assign w_is_wr    = (controlMem == MEM_WR);
  assign w_is_udata = (addr == UART_DATA_ADDR);
  assign w_is_ustat = (addr == UART_STAT_ADDR);

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_is_rd)
          w_next = w_is_ustat ? ST_DONE : (w_is_udata ? ST_UR : ST_RD);
        else if (w_is_wr)
          w_next = w_is_ustat ? ST_DONE : (w_is_udata ? ST_UW : ST_WR1);
        else
          w_next = ST_IDLE;
      end
      ST_RD, ST_WR2, ST_UR, ST_UW: w_next = ST_DONE;
      ST_WR1:                      w_next = ST_WR2;
      default:                     w_next = ST_IDLE;
    endcase
  end

  // r_hold marks a DONE cycle that follows a real bus write, so the data stays driven one extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rdata <= 16'h0000;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= (r_state == ST_WR2) || (r_state == ST_UW);
      if ((r_state == ST_RD) || (r_state == ST_UR))
        r_rdata <= ram_din;
      else if ((r_state == ST_IDLE) && w_is_rd && w_is_ustat)
        r_rdata <= {14'b0, uart_data_ready, uart_tbre & uart_tsre};
    end
  end

  assign w_drive = (r_state == ST_WR1) || (r_state == ST_WR2) || (r_state == ST_UW) ||
                   ((r_state == ST_DONE) && r_hold);

  assign rdata     = r_rdata;
  assign mem_stall = ((r_state == ST_IDLE) && (w_is_rd || w_is_wr)) ||
                     (r_state == ST_RD) || (r_state == ST_WR1) || (r_state == ST_WR2) ||
                     (r_state == ST_UR) || (r_state == ST_UW);
  assign ram_addr  = {2'b00, addr};
  assign ram_doe   = w_drive;
  assign ram_dout  = w_drive ? wdata : 16'h0000;
  assign ram_en_n  = !((r_state == ST_RD) || (r_state == ST_WR1) || (r_state == ST_WR2));
  assign ram_oe_n  = !(r_state == ST_RD);
  assign ram_we_n  = !(r_state == ST_WR2);
  assign uart_rdn  = !(r_state == ST_UR);
  assign uart_wrn  = !(r_state == ST_UW);

endmodule

`default_nettype wire
